// File: rtl/game_timer_ctrl_if.sv
// Signal bundle between game-state logic (master) and the elapsed-time sequencer (slave).
interface game_timer_ctrl_if;
    logic        new_game;
    logic        first_click;
    logic        game_won;
    logic        game_lost;
    logic        pause;
    logic [9:0]  pTime;
    logic [11:0] bcd_time;
    logic        sec_tick;
    logic [1:0]  state;

    modport master (
        output new_game, first_click, game_won, game_lost, pause,
        input  pTime, bcd_time, sec_tick, state
    );

    modport slave (
        input  new_game, first_click, game_won, game_lost, pause,
        output pTime, bcd_time, sec_tick, state
    );
endinterface

// File: rtl/game_timer_ctrl.sv
// Minesweeper elapsed-time sequencer: seconds prescaler plus a saturating 0..MAX_TIME count.
// Define GAME_TIMER_BCD_EN to build the lockstep three-digit BCD counter on bcd_time.
module game_timer_ctrl #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MAX_TIME      = 999
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    game_timer_ctrl_if.slave  bus
);
    localparam int              PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRESC_TC = PW'(TICKS_PER_SEC - 1);
    localparam logic [9:0]      TIME_MAX = 10'(MAX_TIME);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] RUNNING = 2'b01;
    localparam logic [1:0] PAUSED  = 2'b10;
    localparam logic [1:0] FROZEN  = 2'b11;

    logic [1:0]    state_q;
    logic [PW-1:0] presc;
    logic [9:0]    ptime_q;
    logic          tick_q;
    logic          end_game;
    logic          sec_inc;

    assign end_game = bus.game_won | bus.game_lost;

    // A second is credited only when no higher-priority event claims the cycle.
    assign sec_inc = !bus.new_game && !end_game && (state_q == RUNNING) && !bus.pause
                     && (presc == PRESC_TC) && (ptime_q < TIME_MAX);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            presc   <= '0;
            ptime_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= sec_inc;
            if (bus.new_game) begin
                state_q <= IDLE;
                presc   <= '0;
                ptime_q <= '0;
            end else if (end_game) begin
                state_q <= FROZEN;
            end else begin
                case (state_q)
                    IDLE: begin
                        presc <= '0;
                        if (!bus.pause && bus.first_click)
                            state_q <= RUNNING;
                    end
                    RUNNING: begin
                        if (bus.pause)
                            state_q <= PAUSED;
                        else if (presc == PRESC_TC) begin
                            presc <= '0;
                            if (sec_inc)
                                ptime_q <= ptime_q + 10'd1;
                        end else
                            presc <= presc + PW'(1);
                    end
                    PAUSED: begin
                        // Prescaler is held so the partial second carries across the pause.
                        if (!bus.pause)
                            state_q <= RUNNING;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef GAME_TIMER_BCD_EN
    logic [11:0] bcd_q;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] h, t, o;
        h = v[11:8];
        t = v[7:4];
        o = v[3:0];
        if (o == 4'd9) begin
            o = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else
                t = t + 4'd1;
        end else
            o = o + 4'd1;
        return {h, t, o};
    endfunction

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            bcd_q <= '0;
        else if (bus.new_game)
            bcd_q <= '0;
        else if (sec_inc)
            bcd_q <= bcd_inc(bcd_q);
    end

    assign bus.bcd_time = bcd_q;
`else
    assign bus.bcd_time = 12'h000;
`endif

    assign bus.state    = state_q;
    assign bus.pTime    = ptime_q;
    assign bus.sec_tick = tick_q;
endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl: directed scenarios plus randomized play against a seconds-level model.
module tb_game_timer_ctrl;
    localparam int T    = 4;
    localparam int MAXT = 12;

    logic CLOCK_50 = 1'b0;
    logic reset;

    game_timer_ctrl_if bus();

    game_timer_ctrl #(.TICKS_PER_SEC(T), .MAX_TIME(MAXT)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [1:0]  st;
        logic [9:0]  t;
        logic [11:0] bcd;
        logic        tick;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model: mode 0 idle, 1 running, 2 paused, 3 frozen; seconds and cycles-into-second as integers.
    int m_st, m_sec, m_ph;
    bit m_tick;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [11:0] bcd_of(input int s);
`ifdef GAME_TIMER_BCD_EN
        return 12'((s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10));
`else
        return 12'h000;
`endif
    endfunction

    task automatic model_step();
        m_tick = 0;
        if (bus.new_game) begin
            m_st = 0; m_sec = 0; m_ph = 0;
        end else if (bus.game_won || bus.game_lost) begin
            m_st = 3;
        end else if (m_st == 0) begin
            if (bus.first_click && !bus.pause) m_st = 1;
        end else if (m_st == 1) begin
            if (bus.pause) m_st = 2;
            else begin
                m_ph = (m_ph + 1) % T;
                if (m_ph == 0 && m_sec < MAXT) begin
                    m_sec  = m_sec + 1;
                    m_tick = 1;
                end
            end
        end else if (m_st == 2) begin
            if (!bus.pause) m_st = 1;
        end
    endtask

    task automatic cycle(input bit ng, input bit fc, input bit w, input bit l, input bit pz);
        exp_t e;
        #1;
        bus.new_game    = ng;
        bus.first_click = fc;
        bus.game_won    = w;
        bus.game_lost   = l;
        bus.pause       = pz;
        @(posedge CLOCK_50);
        model_step();
        e.st   = 2'(m_st);
        e.t    = 10'(m_sec);
        e.bcd  = bcd_of(m_sec);
        e.tick = m_tick;
        sb.push_back(e);
    endtask

    // Monitor: every registered output is compared each cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("state",    int'(bus.state),    int'(e.st));
                chk("pTime",    int'(bus.pTime),    int'(e.t));
                chk("bcd_time", int'(bus.bcd_time), int'(e.bcd));
                chk("sec_tick", int'(bus.sec_tick), int'(e.tick));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.new_game = 0; bus.first_click = 0; bus.game_won = 0; bus.game_lost = 0; bus.pause = 0;
        m_st = 0; m_sec = 0; m_ph = 0; m_tick = 0;
        repeat (2) @(posedge CLOCK_50);
        #2;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_ptime", int'(bus.pTime), 0);
        chk("rst_bcd",   int'(bus.bcd_time), 0);
        chk("rst_tick",  int'(bus.sec_tick), 0);
        reset = 1'b0;

        repeat (20) cycle(0, 0, 0, 0, 0);
        chk("idle_state", int'(bus.state), 0);

        // Three seconds of play.
        cycle(0, 1, 0, 0, 0);
        repeat (12) cycle(0, 0, 0, 0, 0);
        #2;
        chk("run_ptime", int'(bus.pTime), 3);
`ifdef GAME_TIMER_BCD_EN
        chk("run_bcd", int'(bus.bcd_time), 'h003);
`else
        chk("run_bcd", int'(bus.bcd_time), 0);
`endif

        // Pause after two prescaler counts; the second completes two cycles after resume.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);
        repeat (10) cycle(0, 0, 0, 0, 1);
        #2;
        chk("pause_state", int'(bus.state), 2);
        chk("pause_ptime", int'(bus.pTime), 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        #2;
        chk("resume_tick_early", int'(bus.sec_tick), 0);
        cycle(0, 0, 0, 0, 0);
        #2;
        chk("resume_tick",  int'(bus.sec_tick), 1);
        chk("resume_ptime", int'(bus.pTime), 1);

        // Saturation at MAX_TIME.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (60) cycle(0, 0, 0, 0, 0);
        #2;
        chk("sat_ptime", int'(bus.pTime), 12);
        chk("sat_state", int'(bus.state), 1);
`ifdef GAME_TIMER_BCD_EN
        chk("sat_bcd", int'(bus.bcd_time), 'h012);
`else
        chk("sat_bcd", int'(bus.bcd_time), 0);
`endif

        // game_lost coinciding with the terminal count at five seconds.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (23) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        #2;
        chk("lost_state", int'(bus.state), 3);
        chk("lost_ptime", int'(bus.pTime), 5);
        chk("lost_tick",  int'(bus.sec_tick), 0);
        repeat (6) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        #2;
        chk("newgame_state", int'(bus.state), 0);
        chk("newgame_ptime", int'(bus.pTime), 0);

        // Asynchronous reset in the middle of a cycle while counting.
        cycle(0, 1, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_state", int'(bus.state), 0);
        chk("async_ptime", int'(bus.pTime), 0);
        chk("async_bcd",   int'(bus.bcd_time), 0);
        chk("async_tick",  int'(bus.sec_tick), 0);
        sb.delete();
        m_st = 0; m_sec = 0; m_ph = 0; m_tick = 0;
        repeat (2) @(posedge CLOCK_50);
        #2;
        reset = 1'b0;
        repeat (10) cycle(0, 0, 0, 0, 0);

        // Randomized play.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 12);
        end
        cycle(0, 0, 0, 0, 0);

        @(negedge CLOCK_50);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
